// File: rtl/exu_lsu_pkg.sv
// Shared types and constants for the execute-stage load/store unit.
package exu_lsu_pkg;

  // Architectural data width.
  localparam int unsigned IsaWidth = 32;

  // Access size as carried on ls_size.
  typedef enum logic [1:0] {
    LsB = 2'd0,
    LsH = 2'd1,
    LsW = 2'd2,
    LsX = 2'd3
  } ls_size_e;

  // Operation sequencing.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2,
    StDone = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/exu_lsu_align.sv
// Byte-lane alignment: store mask/data generation and load shift/extension.
module exu_lsu_align
  import exu_lsu_pkg::*;
(
  input  logic [1:0]          i_size,
  input  logic                i_unsigned,
  input  logic [1:0]          i_addr_lo,
  input  logic [IsaWidth-1:0] i_wdata,
  input  logic [IsaWidth-1:0] i_rdata,
  output logic [3:0]          o_wmask,
  output logic [IsaWidth-1:0] o_wdata,
  output logic [IsaWidth-1:0] o_rdata
);

  logic [4:0]          w_shamt;
  logic [IsaWidth-1:0] w_rshift;

  assign w_shamt = {i_addr_lo, 3'b000};

  // Lane shift both directions, then pick mask and extension by size.
  always_comb begin
    o_wdata  = i_wdata << w_shamt;
    w_rshift = i_rdata >> w_shamt;
    o_wmask  = 4'b0000;
    o_rdata  = '0;
    case (i_size)
      LsB: begin
        o_wmask = 4'b0001 << i_addr_lo;
        o_rdata = {{24{~i_unsigned & w_rshift[7]}}, w_rshift[7:0]};
      end
      LsH: begin
        o_wmask = 4'b0011 << i_addr_lo;
        o_rdata = {{16{~i_unsigned & w_rshift[15]}}, w_rshift[15:0]};
      end
      LsW: begin
        o_wmask = 4'b1111;
        o_rdata = w_rshift;
      end
      default: begin
        o_wmask = 4'b0000;
        o_rdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/exu_lsu.sv
// Execute-stage load/store unit: request/response sequencing, input latches and timeout.
module exu_lsu
  import exu_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic                ls_load,
  input  logic                ls_store,
  input  logic [1:0]          ls_size,
  input  logic                ls_unsigned,
  input  logic [IsaWidth-1:0] addr,
  input  logic [IsaWidth-1:0] src2,
  output logic [IsaWidth-1:0] mem_r,
  output logic                lsu_done,
  output logic                lsu_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [IsaWidth-1:0] mem_addr,
  output logic                mem_wen,
  output logic [3:0]          mem_wmask,
  output logic [IsaWidth-1:0] mem_wdata,
  input  logic                mem_resp_valid,
  input  logic [IsaWidth-1:0] mem_rdata
);

  // Counter value seen in the last REQ/RESP cycle before the operation aborts.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  lsu_state_e          r_state, w_state_next;
  logic                w_set_err;
  logic                r_err;
  logic                r_load;
  logic                r_wen;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [IsaWidth-1:0] r_addr;
  logic [IsaWidth-1:0] r_src2;
  logic [IsaWidth-1:0] r_mem_r;
  logic [7:0]          r_cnt;

  logic                w_accept;
  logic                w_illegal;
  logic                w_misalign;
  logic                w_bad;
  logic                w_timeout;
  logic [3:0]          w_wmask;
  logic [IsaWidth-1:0] w_wdata;
  logic [IsaWidth-1:0] w_load_data;

  assign w_accept   = (r_state == StIdle) && lsu_valid;
  assign w_illegal  = (ls_load == ls_store) || (ls_size == LsX);
  assign w_misalign = ((ls_size == LsH) && addr[0]) ||
                      ((ls_size == LsW) && (addr[1:0] != 2'b00));
  assign w_bad      = w_illegal || w_misalign;
  assign w_timeout  = (r_cnt == TimeoutLast);

  exu_lsu_align u_align (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_addr_lo  (r_addr[1:0]),
    .i_wdata    (r_src2),
    .i_rdata    (mem_rdata),
    .o_wmask    (w_wmask),
    .o_wdata    (w_wdata),
    .o_rdata    (w_load_data)
  );

  // Next-state logic; w_set_err flags entry into DONE as a failed operation.
  always_comb begin
    w_state_next = r_state;
    w_set_err    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (lsu_valid) begin
          if (w_bad) begin
            w_state_next = StDone;
            w_set_err    = 1'b1;
          end else begin
            w_state_next = StReq;
          end
        end
      end
      StReq: begin
        // A handshake on the final allowed cycle still aborts: no time is left for the response.
        if (w_timeout) begin
          w_state_next = StDone;
          w_set_err    = 1'b1;
        end else if (mem_req_ready) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        if (mem_resp_valid) begin
          w_state_next = StDone;
        end else if (w_timeout) begin
          w_state_next = StDone;
          w_set_err    = 1'b1;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Error flag lives only for the DONE cycle it was set into.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_set_err;
    end
  end

  // Operation latches, captured on acceptance and held for the whole transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load     <= 1'b0;
      r_wen      <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_src2     <= '0;
    end else if (w_accept) begin
      r_load     <= ls_load;
      r_wen      <= ls_store & ~w_bad;
      r_size     <= ls_size;
      r_unsigned <= ls_unsigned;
      r_addr     <= addr;
      r_src2     <= src2;
    end
  end

  // Load result: cleared on acceptance so stores and errors report zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_r <= '0;
    end else if (w_accept) begin
      r_mem_r <= '0;
    end else if ((r_state == StResp) && mem_resp_valid && r_load) begin
      r_mem_r <= w_load_data;
    end
  end

  // Timeout counter; REQ is only entered from IDLE, so clearing in IDLE clears on entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 8'd0;
    end else if (r_state == StIdle) begin
      r_cnt <= 8'd0;
    end else if ((r_state == StReq) || (r_state == StResp)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign lsu_ready     = (r_state == StIdle);
  assign lsu_done      = (r_state == StDone);
  assign lsu_err       = r_err;
  assign mem_r         = r_mem_r;
  assign mem_req_valid = (r_state == StReq);
  assign mem_addr      = {r_addr[IsaWidth-1:2], 2'b00};
  assign mem_wen       = r_wen;
  assign mem_wmask     = r_wen ? w_wmask : 4'b0000;
  assign mem_wdata     = r_wen ? w_wdata : '0;

endmodule

// File: tb/tb_exu_lsu.sv
// Self-checking bench for exu_lsu: directed scenarios plus randomized operations.
module tb_exu_lsu;

  localparam int unsigned Tmo = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid;
  logic        lsu_ready;
  logic        ls_load;
  logic        ls_store;
  logic [1:0]  ls_size;
  logic        ls_unsigned;
  logic [31:0] addr;
  logic [31:0] src2;
  logic [31:0] mem_r;
  logic        lsu_done;
  logic        lsu_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  exu_lsu #(.TIMEOUT(Tmo)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_valid      (lsu_valid),
    .lsu_ready      (lsu_ready),
    .ls_load        (ls_load),
    .ls_store       (ls_store),
    .ls_size        (ls_size),
    .ls_unsigned    (ls_unsigned),
    .addr           (addr),
    .src2           (src2),
    .mem_r          (mem_r),
    .lsu_done       (lsu_done),
    .lsu_err        (lsu_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wmask      (mem_wmask),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one cycle; all driving and sampling happens 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: byte offsets and spans from plain arithmetic on the address and size.
  function automatic void model(input logic ld, input logic st, input logic [1:0] sz,
                                input logic uns, input logic [31:0] a, input logic [31:0] s2,
                                input logic [31:0] rd, output logic err,
                                output logic [3:0] m, output logic [31:0] wd,
                                output logic [31:0] lv);
    longint unsigned off, nb, v, scale, span;
    off   = 64'(a) % 4;
    nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err   = (ld == st) || (sz == 2'd3) || ((off % nb) != 0);
    scale = 64'd1 << (8 * off);
    span  = 64'd1 << (8 * nb);
    m     = 4'(((64'd1 << nb) - 1) << off);
    wd    = 32'((64'(s2) * scale) % (64'd1 << 32));
    v     = (64'(rd) / scale) % span;
    if (!uns && (v >= span / 2)) v = v + (64'd1 << 32) - span;
    lv    = 32'(v);
    if (err || !ld) lv = 32'd0;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!lsu_ready && (n < 10)) begin
      tick();
      n++;
    end
    chk1({tag, "/ready"}, lsu_ready, 1'b1);
  endtask

  // One complete operation with a responsive memory after rdly/sdly stall cycles.
  task automatic run_op(input string tag, input logic ld, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] s2,
                        input logic [31:0] rd, input int rdly, input int sdly);
    logic        e;
    logic [3:0]  m;
    logic [31:0] wd;
    logic [31:0] lv;
    logic [31:0] wa;
    model(ld, st, sz, uns, a, s2, rd, e, m, wd, lv);
    wa = 32'(64'(a) - (64'(a) % 4));
    wait_ready(tag);
    lsu_valid = 1'b1; ls_load = ld; ls_store = st; ls_size = sz; ls_unsigned = uns;
    addr = a; src2 = s2;
    tick();
    lsu_valid = 1'b0; addr = $urandom; src2 = $urandom;
    if (e) begin
      chk1({tag, "/err_done"}, lsu_done, 1'b1);
      chk1({tag, "/err_flag"}, lsu_err, 1'b1);
      chk1({tag, "/err_noreq"}, mem_req_valid, 1'b0);
      chk({tag, "/err_memr"}, mem_r, 32'd0);
      tick();
      chk1({tag, "/err_done_low"}, lsu_done, 1'b0);
      chk1({tag, "/err_noreq2"}, mem_req_valid, 1'b0);
      return;
    end
    for (int i = 0; i <= rdly; i++) begin
      chk1({tag, "/req_valid"}, mem_req_valid, 1'b1);
      chk({tag, "/req_addr"}, mem_addr, wa);
      chk1({tag, "/req_wen"}, mem_wen, st);
      if (st) begin
        chk({tag, "/req_wmask"}, {28'd0, mem_wmask}, {28'd0, m});
        chk({tag, "/req_wdata"}, mem_wdata, wd);
      end
      chk1({tag, "/req_nodone"}, lsu_done, 1'b0);
      if (i == rdly) mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
    end
    for (int j = 0; j <= sdly; j++) begin
      chk1({tag, "/resp_noreq"}, mem_req_valid, 1'b0);
      chk1({tag, "/resp_nodone"}, lsu_done, 1'b0);
      if (j == sdly) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = rd;
      end else begin
        mem_rdata = $urandom;
      end
      tick();
      mem_resp_valid = 1'b0;
      mem_rdata      = $urandom;
    end
    chk1({tag, "/done"}, lsu_done, 1'b1);
    chk1({tag, "/noerr"}, lsu_err, 1'b0);
    chk({tag, "/mem_r"}, mem_r, lv);
    tick();
    chk1({tag, "/done_pulse"}, lsu_done, 1'b0);
    chk1({tag, "/idle"}, lsu_ready, 1'b1);
    chk({tag, "/mem_r_hold"}, mem_r, lv);
  endtask

  // Word load that never gets a response; ready_at < 0 means ready is never given.
  task automatic run_timeout(input string tag, input int ready_at);
    wait_ready(tag);
    lsu_valid = 1'b1; ls_load = 1'b1; ls_store = 1'b0; ls_size = 2'd2; ls_unsigned = 1'b0;
    addr = 32'h8000_0100; src2 = 32'd0;
    tick();
    lsu_valid = 1'b0;
    for (int k = 1; k <= int'(Tmo); k++) begin
      chk1({tag, "/nodone"}, lsu_done, 1'b0);
      chk1({tag, "/req_valid"}, mem_req_valid, (ready_at < 0) || (k <= ready_at));
      if (k == ready_at) mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
    end
    chk1({tag, "/done"}, lsu_done, 1'b1);
    chk1({tag, "/err"}, lsu_err, 1'b1);
    chk1({tag, "/req_drop"}, mem_req_valid, 1'b0);
    chk({tag, "/mem_r"}, mem_r, 32'd0);
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1234_5678;
    tick();
    mem_resp_valid = 1'b0;
    chk1({tag, "/late_nodone"}, lsu_done, 1'b0);
    chk1({tag, "/late_ready"}, lsu_ready, 1'b1);
    chk({tag, "/late_mem_r"}, mem_r, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "/ready"}, lsu_ready, 1'b1);
    chk1({tag, "/done"}, lsu_done, 1'b0);
    chk1({tag, "/err"}, lsu_err, 1'b0);
    chk1({tag, "/req_valid"}, mem_req_valid, 1'b0);
    chk1({tag, "/wen"}, mem_wen, 1'b0);
    chk({tag, "/wmask"}, {28'd0, mem_wmask}, 32'd0);
    chk({tag, "/addr"}, mem_addr, 32'd0);
    chk({tag, "/wdata"}, mem_wdata, 32'd0);
    chk({tag, "/mem_r"}, mem_r, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ld, st, uns;
    logic [1:0]  sz;
    logic [31:0] a;
    rst = 1'b0; lsu_valid = 1'b0; ls_load = 1'b0; ls_store = 1'b0; ls_size = 2'd0;
    ls_unsigned = 1'b0; addr = 32'd0; src2 = 32'd0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_rdata = 32'd0;
    #3;
    chk_reset_vals("por");
    #10 rst = 1'b1;
    tick();

    run_op("ldw", 1'b1, 1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'd0, 32'hDEAD_BEEF, 0, 0);
    run_op("ldb_s", 1'b1, 1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'd0, 32'h8011_2233, 0, 0);
    run_op("ldb_u", 1'b1, 1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'd0, 32'h8011_2233, 0, 0);
    run_op("sth", 1'b0, 1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_ABCD, 32'hFFFF_FFFF, 4, 1);
    run_op("ldh_s", 1'b1, 1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'd0, 32'h9ABC_0000, 1, 2);
    run_op("ldw_mis", 1'b1, 1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'd0, 32'd0, 0, 0);
    run_op("ldh_mis", 1'b1, 1'b0, 2'd1, 1'b0, 32'h8000_0001, 32'd0, 32'd0, 0, 0);
    run_op("sz3", 1'b1, 1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 0, 0);
    run_op("both", 1'b1, 1'b1, 2'd2, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 0, 0);
    run_op("none", 1'b0, 1'b0, 2'd0, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 0, 0);

    run_timeout("tmo_resp", 1);
    run_timeout("tmo_req", -1);

    // Reset while a store waits for its response.
    wait_ready("rst");
    lsu_valid = 1'b1; ls_load = 1'b0; ls_store = 1'b1; ls_size = 2'd2; ls_unsigned = 1'b0;
    addr = 32'h1000_0010; src2 = 32'hCAFE_F00D;
    tick();
    lsu_valid = 1'b0;
    chk1("rst/pre_wen", mem_wen, 1'b1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    mem_resp_valid = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    chk1("rst/late_nodone", lsu_done, 1'b0);
    chk1("rst/late_ready", lsu_ready, 1'b1);
    run_op("post_rst", 1'b1, 1'b0, 2'd2, 1'b0, 32'h2000_0008, 32'd0, 32'h0BAD_F00D, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ld = 1'($urandom_range(0, 1));
      st = ~ld;
      if ($urandom_range(0, 9) == 0) st = ld;
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      run_op($sformatf("rnd%0d", i), ld, st, sz, uns, a, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
